vga_timing_gen: RTL and testbench

- Generates VGA raster timing (640x480 @ 60 Hz) from the 50 MHz system clock.
- Supplies DrawX/DrawY pixel coordinates to the colour-mapping logic.
- Takes the resulting Red/Green/Blue back and drives registered, blank-gated RGB plus sync pins to the DAC, all aligned with each other.
- Also emits a once-per-frame tick that the bird and pipe motion logic uses to advance position.

---
 rtl/vga_pkg.sv | 50 +++++
 rtl/vga_raster_counter.sv | 72 +++++++
 rtl/vga_timing_gen.sv | 155 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pkg
//  Description : Shared timing defaults, derived raster constants and pixel
//                types for the VGA timing generator and its raster counter.
//                Defaults describe 640x480 @ 60 Hz with a 25 MHz pixel rate.
//  Revision    : 1.0  initial release
// ============================================================================
package vga_pkg;

    // Horizontal timing, in pixels
    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned H_FRONT   = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BACK    = 48;

    // Vertical timing, in lines
    localparam int unsigned V_VISIBLE = 480;
    localparam int unsigned V_FRONT   = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BACK    = 33;

    // Derived totals and sync windows (inclusive bounds)
    localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_START  = H_VISIBLE + H_FRONT;
    localparam int unsigned HS_END    = HS_START + H_SYNC - 1;
    localparam int unsigned VS_START  = V_VISIBLE + V_FRONT;
    localparam int unsigned VS_END    = VS_START + V_SYNC - 1;

    // Raster counters are 10 bits, so both totals must stay at or below 1024.
    localparam int unsigned CNT_W     = 10;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef struct packed {
        logic [7:0] red;
        logic [7:0] green;
        logic [7:0] blue;
    } rgb_t;

    // Unsigned inclusive window test used for both sync pulses.
    function automatic logic in_window(input cnt_t value,
                                       input cnt_t first,
                                       input cnt_t last);
        return (value >= first) && (value <= last);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_raster_counter.sv
`default_nettype none
// ============================================================================
//  Module      : vga_raster_counter
//  Description : Divides the system clock by two into a pixel enable and runs
//                the horizontal / vertical raster counters on it.
//  Revision    : 1.0  initial release
//
//  Ports
//    Clk       in   system clock
//    Reset     in   asynchronous, active-high reset
//    pix_en    out  high on every second Clk; counters advance on edges
//                   where it is high
//    h_cnt     out  horizontal position, 0..H_TOTAL-1
//    v_cnt     out  vertical position, 0..V_TOTAL-1
//    line_wrap out  high during the Clk whose closing edge wraps h_cnt to 0
// ============================================================================
module vga_raster_counter #(
    parameter int unsigned H_TOTAL = vga_pkg::H_TOTAL,
    parameter int unsigned V_TOTAL = vga_pkg::V_TOTAL
) (
    input  logic       Clk,
    input  logic       Reset,
    output logic       pix_en,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic       line_wrap
);
    import vga_pkg::*;

    localparam cnt_t c_h_last = cnt_t'(H_TOTAL - 1);
    localparam cnt_t c_v_last = cnt_t'(V_TOTAL - 1);

    logic r_pix_en;
    cnt_t r_h_cnt;
    cnt_t r_v_cnt;
    logic w_h_last;
    logic w_v_last;

    assign w_h_last = (r_h_cnt == c_h_last);
    assign w_v_last = (r_v_cnt == c_v_last);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_pix_en <= 1'b0;
            r_h_cnt  <= '0;
            r_v_cnt  <= '0;
        end else begin
            r_pix_en <= ~r_pix_en;
            if (r_pix_en) begin
                if (w_h_last) begin
                    // Line end; on the last line this also closes the frame,
                    // so both counters return to zero on the same edge.
                    r_h_cnt <= '0;
                    if (w_v_last) begin
                        r_v_cnt <= '0;
                    end else begin
                        r_v_cnt <= r_v_cnt + cnt_t'(1);
                    end
                end else begin
                    r_h_cnt <= r_h_cnt + cnt_t'(1);
                end
            end
        end
    end

    assign pix_en    = r_pix_en;
    assign h_cnt     = r_h_cnt;
    assign v_cnt     = r_v_cnt;
    assign line_wrap = r_pix_en & w_h_last;

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen
//  Description : VGA raster timing generator. Publishes the live raster
//                position for the colour mapper, registers the returned
//                colour together with sync and blank so all DAC pins move on
//                the same pixel, and flags the start of vertical blanking
//                once per frame.
//  Revision    : 1.0  initial release
//
//  Ports
//    Clk          in   system clock (twice the pixel rate)
//    Reset        in   asynchronous, active-high reset
//    Red_in       in   red for the current DrawX/DrawY
//    Green_in     in   green for the current DrawX/DrawY
//    Blue_in      in   blue for the current DrawX/DrawY
//    DrawX        out  horizontal counter, straight from its register
//    DrawY        out  vertical counter, straight from its register
//    VGA_CLK      out  pixel clock, half the Clk rate, 50% duty
//    VGA_HS       out  horizontal sync, active-low
//    VGA_VS       out  vertical sync, active-low
//    VGA_BLANK_N  out  low outside the visible area
//    VGA_R/G/B    out  registered, blank-gated colour
//    frame_tick   out  one-Clk pulse at the start of vertical blanking
// ============================================================================
module vga_timing_gen #(
    parameter int unsigned H_VISIBLE = vga_pkg::H_VISIBLE,
    parameter int unsigned H_FRONT   = vga_pkg::H_FRONT,
    parameter int unsigned H_SYNC    = vga_pkg::H_SYNC,
    parameter int unsigned H_BACK    = vga_pkg::H_BACK,
    parameter int unsigned V_VISIBLE = vga_pkg::V_VISIBLE,
    parameter int unsigned V_FRONT   = vga_pkg::V_FRONT,
    parameter int unsigned V_SYNC    = vga_pkg::V_SYNC,
    parameter int unsigned V_BACK    = vga_pkg::V_BACK
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] Red_in,
    input  logic [7:0] Green_in,
    input  logic [7:0] Blue_in,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       VGA_CLK,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       frame_tick
);
    import vga_pkg::*;

    localparam int unsigned c_h_total = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned c_v_total = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam cnt_t c_h_visible  = cnt_t'(H_VISIBLE);
    localparam cnt_t c_v_visible  = cnt_t'(V_VISIBLE);
    localparam cnt_t c_hs_start   = cnt_t'(H_VISIBLE + H_FRONT);
    localparam cnt_t c_hs_end     = cnt_t'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam cnt_t c_vs_start   = cnt_t'(V_VISIBLE + V_FRONT);
    localparam cnt_t c_vs_end     = cnt_t'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam cnt_t c_last_vis_v = cnt_t'(V_VISIBLE - 1);

    // ------------------------------------------------------------------
    // Raster position
    // ------------------------------------------------------------------
    logic w_pix_en;
    cnt_t w_h_cnt;
    cnt_t w_v_cnt;
    logic w_line_wrap;

    vga_raster_counter #(
        .H_TOTAL (c_h_total),
        .V_TOTAL (c_v_total)
    ) u_raster (
        .Clk       (Clk),
        .Reset     (Reset),
        .pix_en    (w_pix_en),
        .h_cnt     (w_h_cnt),
        .v_cnt     (w_v_cnt),
        .line_wrap (w_line_wrap)
    );

    assign DrawX = w_h_cnt;
    assign DrawY = w_v_cnt;

    // ------------------------------------------------------------------
    // Output stage: decoded from the counter values before they advance,
    // so every DAC pin trails DrawX/DrawY by exactly one pixel.
    // ------------------------------------------------------------------
    logic w_visible;
    logic w_hs_active;
    logic w_vs_active;
    rgb_t w_rgb_in;

    assign w_visible   = (w_h_cnt < c_h_visible) && (w_v_cnt < c_v_visible);
    assign w_hs_active = in_window(w_h_cnt, c_hs_start, c_hs_end);
    assign w_vs_active = in_window(w_v_cnt, c_vs_start, c_vs_end);
    assign w_rgb_in    = '{red: Red_in, green: Green_in, blue: Blue_in};

    logic r_vga_clk;
    logic r_hs;
    logic r_vs;
    logic r_blank_n;
    rgb_t r_rgb;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_vga_clk <= 1'b0;
            r_hs      <= 1'b1;
            r_vs      <= 1'b1;
            r_blank_n <= 1'b0;
            r_rgb     <= '0;
        end else begin
            r_vga_clk <= w_pix_en;
            if (w_pix_en) begin
                r_hs      <= ~w_hs_active;
                r_vs      <= ~w_vs_active;
                r_blank_n <= w_visible;
                r_rgb     <= w_visible ? w_rgb_in : '0;
            end
        end
    end

    assign VGA_CLK     = r_vga_clk;
    assign VGA_HS      = r_hs;
    assign VGA_VS      = r_vs;
    assign VGA_BLANK_N = r_blank_n;
    assign VGA_R       = r_rgb.red;
    assign VGA_G       = r_rgb.green;
    assign VGA_B       = r_rgb.blue;

    // ------------------------------------------------------------------
    // Frame tick: arm on the edge that moves the raster onto the first
    // blanking line, fire on the following Clk. The arm bit is only set
    // for one Clk because line_wrap is gated by pix_en.
    // ------------------------------------------------------------------
    logic r_vblank_arm;
    logic r_frame_tick;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_vblank_arm <= 1'b0;
            r_frame_tick <= 1'b0;
        end else begin
            r_vblank_arm <= w_line_wrap && (w_v_cnt == c_last_vis_v);
            r_frame_tick <= r_vblank_arm;
        end
    end

    assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_timing_gen
//  Description : Self-checking bench for vga_timing_gen. A compact instance
//                (80x40 raster) covers whole frames, frame ticks and the
//                mid-frame reset; a default 800x525 instance runs alongside
//                to cover the full-size horizontal timing. Expected outputs
//                are computed arithmetically from the number of Clk edges
//                since reset release.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vga_timing_gen;

    // Per-instance timing: index 0 = compact raster, index 1 = defaults
    localparam int unsigned HV  [2] = '{48, 640};
    localparam int unsigned HF  [2] = '{8, 16};
    localparam int unsigned HSW [2] = '{12, 96};
    localparam int unsigned HB  [2] = '{12, 48};
    localparam int unsigned VV  [2] = '{30, 480};
    localparam int unsigned VF  [2] = '{3, 10};
    localparam int unsigned VSW [2] = '{2, 2};
    localparam int unsigned VB  [2] = '{5, 33};

    localparam int unsigned FRAME_CLKS_S = 2 * 80 * 40;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        vclk;
        logic        hs;
        logic        vs;
        logic        blank_n;
        logic [23:0] rgb;
        logic        tick;
    } obs_t;

    logic       Clk   = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] Red_in   = 8'hFF;
    logic [7:0] Green_in = 8'h55;
    logic [7:0] Blue_in  = 8'h00;

    logic [9:0] DrawX_s, DrawY_s, DrawX_f, DrawY_f;
    logic       VGA_CLK_s, VGA_HS_s, VGA_VS_s, VGA_BLANK_N_s, frame_tick_s;
    logic       VGA_CLK_f, VGA_HS_f, VGA_VS_f, VGA_BLANK_N_f, frame_tick_f;
    logic [7:0] VGA_R_s, VGA_G_s, VGA_B_s, VGA_R_f, VGA_G_f, VGA_B_f;

    always #5 Clk = ~Clk;

    vga_timing_gen #(
        .H_VISIBLE (48), .H_FRONT (8), .H_SYNC (12), .H_BACK (12),
        .V_VISIBLE (30), .V_FRONT (3), .V_SYNC (2),  .V_BACK (5)
    ) u_dut_small (
        .Clk (Clk), .Reset (Reset),
        .Red_in (Red_in), .Green_in (Green_in), .Blue_in (Blue_in),
        .DrawX (DrawX_s), .DrawY (DrawY_s), .VGA_CLK (VGA_CLK_s),
        .VGA_HS (VGA_HS_s), .VGA_VS (VGA_VS_s), .VGA_BLANK_N (VGA_BLANK_N_s),
        .VGA_R (VGA_R_s), .VGA_G (VGA_G_s), .VGA_B (VGA_B_s),
        .frame_tick (frame_tick_s)
    );

    vga_timing_gen u_dut_full (
        .Clk (Clk), .Reset (Reset),
        .Red_in (Red_in), .Green_in (Green_in), .Blue_in (Blue_in),
        .DrawX (DrawX_f), .DrawY (DrawY_f), .VGA_CLK (VGA_CLK_f),
        .VGA_HS (VGA_HS_f), .VGA_VS (VGA_VS_f), .VGA_BLANK_N (VGA_BLANK_N_f),
        .VGA_R (VGA_R_f), .VGA_G (VGA_G_f), .VGA_B (VGA_B_f),
        .frame_tick (frame_tick_f)
    );

    obs_t obs_s, obs_f;
    assign obs_s = {DrawX_s, DrawY_s, VGA_CLK_s, VGA_HS_s, VGA_VS_s, VGA_BLANK_N_s,
                    VGA_R_s, VGA_G_s, VGA_B_s, frame_tick_s};
    assign obs_f = {DrawX_f, DrawY_f, VGA_CLK_f, VGA_HS_f, VGA_VS_f, VGA_BLANK_N_f,
                    VGA_R_f, VGA_G_f, VGA_B_f, frame_tick_f};

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_asserts = 0;
    int n_fail    = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_asserts++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference: edge count since release plus the colour sampled on the
    // most recent pixel step fully determine every output.
    // ------------------------------------------------------------------
    int unsigned n_edges = 0;
    logic [23:0] cap_rgb = 24'h0;

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            n_edges = 0;
            cap_rgb = 24'h0;
        end else begin
            n_edges = n_edges + 1;
            if (n_edges % 2 == 0) cap_rgb = {Red_in, Green_in, Blue_in};
        end
    end

    function automatic obs_t expect_at(input int i, input int unsigned n, input logic [23:0] rgb);
        obs_t e;
        int unsigned htot, vtot, frame, u, p, q, qx, qy;
        logic vis;
        htot  = HV[i] + HF[i] + HSW[i] + HB[i];
        vtot  = VV[i] + VF[i] + VSW[i] + VB[i];
        frame = htot * vtot;
        u     = n / 2;                 // pixel steps taken so far
        p     = u % frame;
        e.x   = 10'(p % htot);
        e.y   = 10'(p / htot);
        e.vclk    = (n == 0) ? 1'b0 : ((n - 1) % 2 == 1);
        e.hs      = 1'b1;
        e.vs      = 1'b1;
        e.blank_n = 1'b0;
        e.rgb     = 24'h0;
        if (u != 0) begin
            q   = (u - 1) % frame;     // pixel the output stage describes
            qx  = q % htot;
            qy  = q / htot;
            vis = (qx < HV[i]) && (qy < VV[i]);
            e.hs = !((qx >= HV[i] + HF[i]) && (qx < HV[i] + HF[i] + HSW[i]));
            e.vs = !((qy >= VV[i] + VF[i]) && (qy < VV[i] + VF[i] + VSW[i]));
            e.blank_n = vis;
            e.rgb     = vis ? rgb : 24'h0;
        end
        e.tick = (n % 2 == 1) && (((n - 1) / 2) % frame == VV[i] * htot);
        return e;
    endfunction

    // ------------------------------------------------------------------
    // Per-cycle comparison plus sync / tick interval measurements
    // ------------------------------------------------------------------
    bit          checking_on = 1'b0;
    string       TAG [2] = '{"small", "full"};
    int unsigned cyc = 0;
    obs_t        prev [2];
    int unsigned last_hs [2], last_vs [2], last_tick [2];
    bit          hs_seen [2], vs_seen [2], tick_seen [2];
    int unsigned tick_cnt [2];

    always @(negedge Clk) begin
        obs_t o, e;
        int unsigned htot;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            o    = (i == 0) ? obs_s : obs_f;
            htot = HV[i] + HF[i] + HSW[i] + HB[i];
            if (Reset) begin
                hs_seen[i] = 1'b0; vs_seen[i] = 1'b0; tick_seen[i] = 1'b0;
                tick_cnt[i] = 0;
            end
            if (checking_on) begin
                e = expect_at(i, n_edges, cap_rgb);
                check({TAG[i], ".xy"},   {o.x, o.y}, {e.x, e.y});
                check({TAG[i], ".vclk"}, o.vclk, e.vclk);
                check({TAG[i], ".sync_blank"}, {o.hs, o.vs, o.blank_n}, {e.hs, e.vs, e.blank_n});
                check({TAG[i], ".rgb"},  o.rgb, e.rgb);
                check({TAG[i], ".tick"}, o.tick, e.tick);
                if (!Reset) begin
                    if (prev[i].hs && !o.hs) begin
                        check({TAG[i], ".hs_fall_x"}, o.x, HV[i] + HF[i] + 1);
                        if (hs_seen[i]) check({TAG[i], ".line_period"}, cyc - last_hs[i], 2 * htot);
                        last_hs[i] = cyc; hs_seen[i] = 1'b1;
                    end
                    if (!prev[i].hs && o.hs && hs_seen[i])
                        check({TAG[i], ".hs_width"}, cyc - last_hs[i], 2 * HSW[i]);
                    if (prev[i].vs && !o.vs) begin
                        check({TAG[i], ".vs_fall_xy"}, {o.x, o.y}, {10'd1, 10'(VV[i] + VF[i])});
                        last_vs[i] = cyc; vs_seen[i] = 1'b1;
                    end
                    if (!prev[i].vs && o.vs && vs_seen[i])
                        check({TAG[i], ".vs_width"}, cyc - last_vs[i], 2 * VSW[i] * htot);
                    if (o.tick) begin
                        tick_cnt[i]++;
                        check({TAG[i], ".tick_xy"}, {o.x, o.y}, {10'd0, 10'(VV[i])});
                        if (tick_seen[i])
                            check({TAG[i], ".frame_period"}, cyc - last_tick[i],
                                  2 * htot * (VV[i] + VF[i] + VSW[i] + VB[i]));
                        last_tick[i] = cyc; tick_seen[i] = 1'b1;
                    end
                end
            end
            prev[i] = o;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        bit found;
        repeat (2) @(posedge Clk);
        #2 checking_on = 1'b1;
        repeat (3) @(posedge Clk);
        #2 Reset = 1'b0;

        // First frame with a fixed colour, then two frames of random colour
        repeat (FRAME_CLKS_S) begin
            @(posedge Clk);
            #2;
        end
        repeat (2 * FRAME_CLKS_S) begin
            @(posedge Clk);
            #2 {Red_in, Green_in, Blue_in} = 24'($urandom);
        end
        check("tick_count_3_frames", tick_cnt[0], 3);

        // Mid-frame reset once the compact raster reaches (30, 20)
        found = 1'b0;
        for (int k = 0; k < int'(FRAME_CLKS_S) + 10; k++) begin
            @(posedge Clk);
            #2 {Red_in, Green_in, Blue_in} = 24'($urandom);
            if (DrawX_s == 10'd30 && DrawY_s == 10'd20) begin
                found = 1'b1;
                break;
            end
        end
        check("reach_mid_frame", found, 1'b1);
        Reset = 1'b1;
        #1;
        check("async_rst.xy_small", {DrawX_s, DrawY_s}, 20'd0);
        check("async_rst.xy_full",  {DrawX_f, DrawY_f}, 20'd0);
        check("async_rst.ctl_small",
              {VGA_CLK_s, VGA_HS_s, VGA_VS_s, VGA_BLANK_N_s, frame_tick_s}, 5'b01100);
        check("async_rst.rgb_small", {VGA_R_s, VGA_G_s, VGA_B_s}, 24'h0);
        repeat (3) @(posedge Clk);
        #2 Reset = 1'b0;

        repeat (FRAME_CLKS_S + 200) begin
            @(posedge Clk);
            #2 {Red_in, Green_in, Blue_in} = 24'($urandom);
        end
        check("tick_count_after_reset", tick_cnt[0], 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
